regfile_sb: RTL and testbench

Parametrised multi-port register file with write-to-read bypass and an integrated busy scoreboard. It replaces the fixed 16x16, two-read-port register file in the CPU decode stage. The scoreboard tracks registers with an in-flight write so that the hazard unit can stall on read-after-write without a separate structure. Register storage, bypass and busy tracking are all contained in one block.

---
 rtl/regfile_sb.sv | 92 +++++++++
 tb/tb_regfile_sb.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write-to-read bypass and busy scoreboard
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_RD*IDX_W-1:0]         rd_id,
    output logic [NUM_RD*DATA_W-1:0]        rd_data,
    output logic [NUM_RD-1:0]               rd_busy,
    input  logic                            wr_en,
    input  logic [IDX_W-1:0]                wr_id,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            sb_set,
    input  logic [IDX_W-1:0]                sb_id,
    output logic [$clog2(NUM_REGS+1)-1:0]   busy_cnt
);

    localparam int CNT_W    = $clog2(NUM_REGS+1);
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    busy_cnt_q, busy_cnt_d;

    logic wr_ok;
    logic set_ok;
    logic cnt_inc;
    logic cnt_dec;

    // Register 0 swallows writes and issue marks when hardwired to zero
    assign wr_ok  = wr_en  && !(HAS_ZERO && (wr_id == '0));
    assign set_ok = sb_set && !(HAS_ZERO && (sb_id == '0));

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_ok) begin
            mem_d[wr_id]  = wr_data;
            busy_d[wr_id] = 1'b0;
        end
        // Applied after the clear so a new producer on the same register wins
        if (set_ok) begin
            busy_d[sb_id] = 1'b1;
        end
    end

    // Only a real 0->1 or 1->0 transition moves the count
    assign cnt_inc = set_ok && !busy_q[sb_id];
    assign cnt_dec = wr_ok && busy_q[wr_id] && !(set_ok && (sb_id == wr_id));

    always_comb begin
        busy_cnt_d = busy_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [IDX_W-1:0] rid;
        logic             byp;
        logic             is_zero;

        assign rid     = rd_id[p*IDX_W +: IDX_W];
        assign is_zero = HAS_ZERO && (rid == '0);
        // A completing write supplies valid data, so it also hides the busy flag
        assign byp     = !rst && wr_ok && (wr_id == rid);

        assign rd_data[p*DATA_W +: DATA_W] = (rst || is_zero) ? '0 :
                                             byp              ? wr_data :
                                                                mem_q[rid];
        assign rd_busy[p] = !rst && busy_q[rid] && !byp;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized and directed bench for regfile_sb against a behavioural model
module tb_regfile_sb;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst;

    logic [7:0]  s_rd_id;
    logic        s_wr_en;
    logic [3:0]  s_wr_id;
    logic [15:0] s_wr_data;
    logic        s_sb_set;
    logic [3:0]  s_sb_id;

    logic [31:0] rd_data_a, rd_data_z;
    logic [1:0]  rd_busy_a, rd_busy_z;
    logic [4:0]  busy_cnt_a, busy_cnt_z;

    logic [14:0] w_rd_id;
    logic        w_wr_en;
    logic [4:0]  w_wr_id;
    logic [31:0] w_wr_data;
    logic        w_sb_set;
    logic [4:0]  w_sb_id;
    logic [95:0] rd_data_w;
    logic [2:0]  rd_busy_w;
    logic [5:0]  busy_cnt_w;

    regfile_sb dut_a (
        .clk(clk), .rst(rst), .rd_id(s_rd_id), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(s_wr_en), .wr_id(s_wr_id), .wr_data(s_wr_data),
        .sb_set(s_sb_set), .sb_id(s_sb_id), .busy_cnt(busy_cnt_a)
    );

    regfile_sb #(.ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .rd_id(s_rd_id), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
        .wr_en(s_wr_en), .wr_id(s_wr_id), .wr_data(s_wr_data),
        .sb_set(s_sb_set), .sb_id(s_sb_id), .busy_cnt(busy_cnt_z)
    );

    regfile_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(3)) dut_w (
        .clk(clk), .rst(rst), .rd_id(w_rd_id), .rd_data(rd_data_w), .rd_busy(rd_busy_w),
        .wr_en(w_wr_en), .wr_id(w_wr_id), .wr_data(w_wr_data),
        .sb_set(w_sb_set), .sb_id(w_sb_id), .busy_cnt(busy_cnt_w)
    );

    // Model: k=0 dut_a, k=1 dut_z, k=2 dut_w
    int          nregs [3] = '{16, 16, 32};
    int          nrd   [3] = '{2, 2, 3};
    bit          zreg  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] dmask [3] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFFF};

    logic [31:0] m_mem  [3][32];
    bit          m_busy [3][32];
    int          m_cnt  [3];

    int          st_rid [3][4];
    bit          st_we  [3];
    bit          st_ss  [3];
    int          st_wid [3];
    int          st_sid [3];
    logic [31:0] st_wd  [3];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[k][r]  = '0;
                m_busy[k][r] = 1'b0;
            end
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit w_eff;
                bit s_eff;
                w_eff = st_we[k] && !(zreg[k] && st_wid[k] == 0);
                s_eff = st_ss[k] && !(zreg[k] && st_sid[k] == 0);
                if (w_eff) begin
                    m_mem[k][st_wid[k]]  = st_wd[k] & dmask[k];
                    m_busy[k][st_wid[k]] = 1'b0;
                end
                if (s_eff) m_busy[k][st_sid[k]] = 1'b1;
                m_cnt[k] = 0;
                for (int r = 0; r < nregs[k]; r++) m_cnt[k] += int'(m_busy[k][r]);
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(int k, int r);
        if (rst) return 32'h0;
        if (zreg[k] && r == 0) return 32'h0;
        if (st_we[k] && st_wid[k] == r) return st_wd[k] & dmask[k];
        return m_mem[k][r];
    endfunction

    function automatic logic exp_busy(int k, int r);
        if (rst) return 1'b0;
        if (st_we[k] && st_wid[k] == r) return 1'b0;
        return m_busy[k][r];
    endfunction

    function automatic logic [31:0] got_rd(int k, int p);
        case (k)
            0:       return 32'(rd_data_a[p*16 +: 16]);
            1:       return 32'(rd_data_z[p*16 +: 16]);
            default: return rd_data_w[p*32 +: 32];
        endcase
    endfunction

    function automatic logic got_busy(int k, int p);
        case (k)
            0:       return rd_busy_a[p];
            1:       return rd_busy_z[p];
            default: return rd_busy_w[p];
        endcase
    endfunction

    function automatic int got_cnt(int k);
        case (k)
            0:       return int'(busy_cnt_a);
            1:       return int'(busy_cnt_z);
            default: return int'(busy_cnt_w);
        endcase
    endfunction

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < nrd[k]; p++) begin
                check($sformatf("rd_data k%0d p%0d r%0d", k, p, st_rid[k][p]),
                      got_rd(k, p), exp_rd(k, st_rid[k][p]));
                check($sformatf("rd_busy k%0d p%0d r%0d", k, p, st_rid[k][p]),
                      got_busy(k, p), exp_busy(k, st_rid[k][p]));
            end
            check($sformatf("busy_cnt k%0d", k), got_cnt(k), m_cnt[k]);
        end
    endtask

    task automatic apply();
        st_we[1]  = st_we[0];
        st_ss[1]  = st_ss[0];
        st_wid[1] = st_wid[0];
        st_sid[1] = st_sid[0];
        st_wd[1]  = st_wd[0];
        for (int p = 0; p < 4; p++) st_rid[1][p] = st_rid[0][p];
        s_wr_en   = st_we[0];
        s_wr_id   = 4'(st_wid[0]);
        s_wr_data = 16'(st_wd[0]);
        s_sb_set  = st_ss[0];
        s_sb_id   = 4'(st_sid[0]);
        for (int p = 0; p < 2; p++) s_rd_id[p*4 +: 4] = 4'(st_rid[0][p]);
        w_wr_en   = st_we[2];
        w_wr_id   = 5'(st_wid[2]);
        w_wr_data = st_wd[2];
        w_sb_set  = st_ss[2];
        w_sb_id   = 5'(st_sid[2]);
        for (int p = 0; p < 3; p++) w_rd_id[p*5 +: 5] = 5'(st_rid[2][p]);
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            st_we[k] = 1'b0;
            st_ss[k] = 1'b0;
            st_wid[k] = 0;
            st_sid[k] = 0;
            st_wd[k]  = '0;
        end
    endtask

    task automatic s_wr(input int id, input logic [31:0] d);
        for (int k = 0; k < 3; k++) begin
            st_we[k] = 1'b1;
            st_wid[k] = id;
            st_wd[k]  = d;
        end
    endtask

    task automatic s_sb(input int id);
        for (int k = 0; k < 3; k++) begin
            st_ss[k] = 1'b1;
            st_sid[k] = id;
        end
    endtask

    task automatic s_rd(input int p, input int id);
        for (int k = 0; k < 3; k++) begin
            if (p < nrd[k]) st_rid[k][p] = id;
        end
    endtask

    task automatic rand_stim();
        for (int k = 0; k < 3; k += 2) begin
            int n;
            n = nregs[k];
            st_we[k]  = ($urandom % 3) != 0;
            st_wid[k] = int'($urandom % n);
            st_wd[k]  = $urandom;
            st_ss[k]  = ($urandom % 2) != 0;
            st_sid[k] = ($urandom % 4 == 0) ? st_wid[k] : int'($urandom % n);
            for (int p = 0; p < 4; p++)
                st_rid[k][p] = ($urandom % 3 == 0) ? st_wid[k] : int'($urandom % n);
        end
    endtask

    task automatic pre();
        apply();
        #1 check_all();
    endtask

    task automatic post();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cycle();
        pre();
        post();
    endtask

    task automatic pulse_reset();
        idle();
        apply();
        #1 rst = 1'b1;
        model_clear();
        #1 check_all();
        #1 rst = 1'b0;
        #1 check_all();
        post();
    endtask

    int wide_ids [4] = '{1, 9, 20, 31};

    initial begin
        rst = 1'b1;
        model_clear();
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < 4; p++) st_rid[k][p] = 0;
        repeat (3) begin
            rand_stim();
            cycle();
        end
        rst = 1'b0;

        idle();
        for (int r = 0; r < 16; r++) begin
            s_rd(0, r);
            s_rd(1, 15 - r);
            s_rd(2, r + 16);
            cycle();
        end

        idle();
        s_wr(5, 32'hBEEF);
        s_rd(0, 5);
        pre();
        check("bypass same cycle", rd_data_a[15:0], 16'hBEEF);
        post();
        idle();
        s_rd(0, 5);
        s_rd(1, 5);
        pre();
        check("stored p0", rd_data_a[15:0], 16'hBEEF);
        check("stored p1", rd_data_a[31:16], 16'hBEEF);
        post();

        idle();
        s_sb(3);
        cycle();
        idle();
        s_rd(0, 3);
        pre();
        check("sb busy r3", rd_busy_a[0], 1'b1);
        check("sb cnt 1", busy_cnt_a, 5'd1);
        post();
        s_wr(3, 32'h1234);
        pre();
        check("sb write hides busy", rd_busy_a[0], 1'b0);
        check("sb write bypass", rd_data_a[15:0], 16'h1234);
        post();
        idle();
        pre();
        check("sb cnt cleared", busy_cnt_a, 5'd0);
        post();

        idle();
        s_sb(7);
        cycle();
        idle();
        s_sb(7);
        s_wr(7, 32'h00AA);
        cycle();
        idle();
        s_rd(0, 7);
        pre();
        check("set wins busy", rd_busy_a[0], 1'b1);
        check("set wins cnt", busy_cnt_a, 5'd1);
        check("set wins data", rd_data_a[15:0], 16'h00AA);
        post();
        s_sb(8);
        s_wr(7, 32'h0055);
        cycle();
        idle();
        s_rd(0, 8);
        s_rd(1, 7);
        pre();
        check("swap cnt", busy_cnt_a, 5'd1);
        check("swap r8 busy", rd_busy_a[0], 1'b1);
        check("swap r7 free", rd_busy_a[1], 1'b0);
        post();

        pulse_reset();
        idle();
        s_wr(0, 32'hFFFF);
        s_sb(0);
        s_rd(0, 0);
        pre();
        check("zero rd", rd_data_z[15:0], 16'h0);
        check("zero busy", rd_busy_z[0], 1'b0);
        check("nonzero bypass r0", rd_data_a[15:0], 16'hFFFF);
        post();
        idle();
        pre();
        check("zero cnt", busy_cnt_z, 5'd0);
        post();
        for (int i = 1; i < 16; i++) begin
            idle();
            s_sb(i);
            cycle();
        end
        idle();
        pre();
        check("zero cnt max", busy_cnt_z, 5'd15);
        check("full cnt max", busy_cnt_a, 5'd16);
        post();

        pulse_reset();
        idle();
        st_we[2] = 1'b1;
        st_wid[2] = 31;
        st_wd[2]  = 32'hDEADBEEF;
        cycle();
        for (int i = 0; i < 4; i++) begin
            idle();
            st_ss[2]  = 1'b1;
            st_sid[2] = wide_ids[i];
            cycle();
        end
        idle();
        st_rid[2][0] = 31;
        st_rid[2][1] = 20;
        st_rid[2][2] = 9;
        pre();
        check("wide data", rd_data_w[31:0], 32'hDEADBEEF);
        check("wide cnt", busy_cnt_w, 6'd4);
        check("wide busy", rd_busy_w, 3'b111);
        #1 rst = 1'b1;
        model_clear();
        #1;
        check("async rst cnt", busy_cnt_w, 6'd0);
        check("async rst data", rd_data_w, 96'h0);
        check("async rst busy", rd_busy_w, 3'b000);
        #1 rst = 1'b0;
        #1;
        check("after rst data", rd_data_w[31:0], 32'h0);
        check("after rst busy", rd_busy_w, 3'b000);
        check("after rst cnt", busy_cnt_w, 6'd0);
        check_all();
        post();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 200 == 0) begin
                pulse_reset();
            end else begin
                rand_stim();
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
